// File: rtl/clk_gen_tune_ctrl.sv
// Tap-select calibration controller: 4-step successive-approximation search over a 16:1 tap mux.
// Optional post-lock tracking is enabled by defining CLK_GEN_TUNE_TRACK_EN.
module clk_gen_tune_ctrl #(
    parameter int         CNT_W       = 16,
    parameter int         SETTLE_CYC  = 8,
    parameter int         TIMEOUT_CYC = 1024,
    parameter logic [3:0] RESET_SEL   = 4'd0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] target_i,
    input  logic             manual_en_i,
    input  logic [3:0]       manual_sel_i,
    output logic             meas_start_o,
    input  logic             meas_valid_i,
    input  logic [CNT_W-1:0] meas_count_i,
    output logic [3:0]       sel_o,
    output logic             busy_o,
    output logic             locked_o,
    output logic             err_o
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_SETTLE, S_REQ, S_WAIT, S_DECIDE, S_DONE, S_ERR, S_TREQ, S_TWAIT
    } state_t;

    state_t           state, nxt;
    logic [3:0]       sel_q;
    logic [1:0]       idx;
    logic [CNT_W-1:0] target_q, meas_q;
    logic [SW-1:0]    settle_cnt;
    logic [TW-1:0]    to_cnt;
    logic [3:0]       bit_mask, kept, next_code;
    logic             pass, settle_done, to_done;

    assign bit_mask    = 4'b0001 << idx;
    assign pass        = (meas_q >= target_q);
    assign kept        = pass ? sel_q : (sel_q & ~bit_mask);
    assign next_code   = (idx != 2'd0) ? (kept | (bit_mask >> 1)) : kept;
    assign settle_done = (settle_cnt == SETTLE_LAST);
    assign to_done     = (to_cnt == TO_LAST);
    assign sel_o       = sel_q;

`ifdef CLK_GEN_TUNE_TRACK_EN
    logic [7:0]     track_cnt;
    logic [CNT_W:0] hi_thr;
    logic           track_due;
    assign hi_thr    = {1'b0, target_q} + {1'b0, (target_q >> 4)};
    assign track_due = (track_cnt == 8'hFF);
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) state <= S_IDLE;
        else         state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (manual_en_i) begin
            nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_ERR: if (start_i) nxt = S_SETTLE;
                S_DONE: begin
                    if (start_i) nxt = S_SETTLE;
`ifdef CLK_GEN_TUNE_TRACK_EN
                    else if (track_due) nxt = S_TREQ;
`endif
                end
                S_SETTLE: if (settle_done) nxt = S_REQ;
                S_REQ:    nxt = S_WAIT;
                S_WAIT: begin
                    if (meas_valid_i) nxt = S_DECIDE;
                    else if (to_done) nxt = S_ERR;
                end
                S_DECIDE: nxt = (idx == 2'd0) ? S_DONE : S_SETTLE;
`ifdef CLK_GEN_TUNE_TRACK_EN
                S_TREQ:   nxt = S_TWAIT;
                S_TWAIT: begin
                    if (meas_valid_i) nxt = S_DONE;
                    else if (to_done) nxt = S_ERR;
                end
`endif
                default:  nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        meas_start_o = (state == S_REQ) || (state == S_TREQ);
        busy_o       = (state == S_SETTLE) || (state == S_REQ) ||
                       (state == S_WAIT) || (state == S_DECIDE);
        locked_o     = (state == S_DONE) || (state == S_TREQ) || (state == S_TWAIT);
        err_o        = (state == S_ERR);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sel_q      <= RESET_SEL;
            idx        <= 2'd0;
            target_q   <= '0;
            meas_q     <= '0;
            settle_cnt <= '0;
            to_cnt     <= '0;
`ifdef CLK_GEN_TUNE_TRACK_EN
            track_cnt  <= '0;
`endif
        end else begin
            settle_cnt <= (state == S_SETTLE) ? settle_cnt + 1'b1 : '0;
            to_cnt     <= (state == S_WAIT || state == S_TWAIT) ? to_cnt + 1'b1 : '0;
`ifdef CLK_GEN_TUNE_TRACK_EN
            track_cnt  <= (state == S_DONE) ? track_cnt + 1'b1 : '0;
`endif
            if (manual_en_i) begin
                sel_q <= manual_sel_i;
            end else begin
                case (state)
                    S_IDLE, S_DONE, S_ERR: begin
                        if (start_i) begin
                            sel_q    <= 4'b1000;
                            idx      <= 2'd3;
                            target_q <= target_i;
                        end
                    end
                    S_WAIT: begin
                        // On timeout the bit under test is undecided, so drop it.
                        if (meas_valid_i) meas_q <= meas_count_i;
                        else if (to_done) sel_q <= sel_q & ~bit_mask;
                    end
                    S_DECIDE: begin
                        sel_q <= next_code;
                        if (idx != 2'd0) idx <= idx - 1'b1;
                    end
`ifdef CLK_GEN_TUNE_TRACK_EN
                    S_TWAIT: begin
                        if (meas_valid_i) begin
                            if (meas_count_i < target_q && sel_q != 4'd0)
                                sel_q <= sel_q - 1'b1;
                            else if ({1'b0, meas_count_i} >= hi_thr && sel_q != 4'd15)
                                sel_q <= sel_q + 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_gen_tune_ctrl.sv
// Randomized self-checking bench for clk_gen_tune_ctrl; a responder answers measurement
// requests from a monotonic count table and results are compared with a brute-force model.
module tb_clk_gen_tune_ctrl;

    logic        clk = 0;
    logic        reset_i = 1;
    logic        start_i = 0;
    logic [15:0] target_i = 0;
    logic        manual_en_i = 0;
    logic [3:0]  manual_sel_i = 0;
    logic        meas_start_o;
    logic        meas_valid_i;
    logic [15:0] meas_count_i;
    logic [3:0]  sel_o;
    logic        busy_o, locked_o, err_o;

    int n_cmp = 0, n_err = 0;
    int mode = 0;
    int n_req = 0, req_in_search = 0;
    bit hold2 = 0;
    logic [15:0] tab [16];

    clk_gen_tune_ctrl dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .target_i(target_i),
        .manual_en_i(manual_en_i), .manual_sel_i(manual_sel_i),
        .meas_start_o(meas_start_o), .meas_valid_i(meas_valid_i), .meas_count_i(meas_count_i),
        .sel_o(sel_o), .busy_o(busy_o), .locked_o(locked_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] cnt_of(input logic [3:0] s);
        case (mode)
            0:       return 16'(2000 - 100 * int'(s));
            1:       return 16'd5000;
            2:       return 16'd0;
            3:       return 16'd950;
            default: return tab[s];
        endcase
    endfunction

    // Monotonic plant: the answer is simply the largest tap still meeting the target.
    function automatic logic [3:0] best_sel(input logic [15:0] tgt);
        logic [3:0] res = 4'd0;
        for (int s = 0; s < 16; s++)
            if (cnt_of(4'(s)) >= tgt) res = 4'(s);
        return res;
    endfunction

    initial begin
        meas_valid_i = 0;
        meas_count_i = 0;
        forever begin
            @(negedge clk);
            if (meas_start_o) begin
                n_req++;
                req_in_search++;
                if (!(hold2 && req_in_search >= 2)) begin
                    repeat ($urandom_range(1, 12)) @(negedge clk);
                    meas_count_i = cnt_of(sel_o);
                    meas_valid_i = 1;
                    @(negedge clk);
                    meas_valid_i = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic do_start();
        @(negedge clk);
        req_in_search = 0;
        start_i = 1;
        @(negedge clk);
        start_i = 0;
    endtask

    task automatic wait_end(input string nm);
        int k = 0;
        while (!(locked_o || err_o) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (!(locked_o || err_o)) begin
            n_cmp++; n_err++;
            $display("FAIL %s_end: no lock/err after %0d cycles, required completion", nm, k);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({sel_o, busy_o, locked_o, err_o, meas_start_o} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_state: sel=%0d busy=%b lock=%b err=%b ms=%b, required all 0",
                     sel_o, busy_o, locked_o, err_o, meas_start_o);
        end
        reset_i = 0;
    endtask

    task automatic test_search(input int m, input logic [15:0] tgt, input bit scramble,
                               input string nm);
        logic [3:0] exp_sel;
        int snap;
        mode = m;
        target_i = tgt;
        exp_sel = best_sel(tgt);
        snap = n_req;
        do_start();
        if (scramble) target_i = 16'($urandom);
        n_cmp++;
        if (!(busy_o === 1'b1 && sel_o === 4'd8 && locked_o === 1'b0 && err_o === 1'b0)) begin
            n_err++;
            $display("FAIL %s_first_trial: busy=%b sel=%0d lock=%b err=%b, required busy=1 sel=8",
                     nm, busy_o, sel_o, locked_o, err_o);
        end
        wait_end(nm);
        n_cmp++;
        if (!(sel_o === exp_sel && locked_o === 1'b1 && busy_o === 1'b0 && err_o === 1'b0)) begin
            n_err++;
            $display("FAIL %s_result: sel=%0d lock=%b busy=%b err=%b, required sel=%0d lock=1",
                     nm, sel_o, locked_o, busy_o, err_o, exp_sel);
        end
        n_cmp++;
        if (n_req - snap != 4) begin
            n_err++;
            $display("FAIL %s_trials: %0d measurements, required 4", nm, n_req - snap);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            tab[0] = 16'($urandom_range(3000, 4000));
            for (int s = 1; s < 16; s++) tab[s] = tab[s-1] - 16'($urandom_range(0, 250));
            test_search(4, 16'($urandom_range(0, 4100)), 1'b1, "random");
        end
    endtask

    task automatic test_timeout();
        mode = 0;
        target_i = 16'd1000;
        hold2 = 1;
        do_start();
        wait_end("timeout");
        n_cmp++;
        if (!(err_o === 1'b1 && sel_o === 4'd8 && busy_o === 1'b0 && locked_o === 1'b0)) begin
            n_err++;
            $display("FAIL timeout_err: err=%b sel=%0d busy=%b lock=%b, required err=1 sel=8 busy=0",
                     err_o, sel_o, busy_o, locked_o);
        end
        hold2 = 0;
        do_start();
        n_cmp++;
        if (!(err_o === 1'b0 && busy_o === 1'b1)) begin
            n_err++;
            $display("FAIL timeout_restart: err=%b busy=%b, required err=0 busy=1", err_o, busy_o);
        end
        wait_end("timeout_retry");
        n_cmp++;
        if (!(sel_o === 4'd10 && locked_o === 1'b1)) begin
            n_err++;
            $display("FAIL timeout_retry_result: sel=%0d lock=%b, required sel=10 lock=1",
                     sel_o, locked_o);
        end
    endtask

    task automatic test_manual();
        int snap;
        mode = 0;
        target_i = 16'd1000;
        do_start();
        repeat (15) @(negedge clk);
        manual_en_i = 1;
        manual_sel_i = 4'd5;
        @(negedge clk);
        n_cmp++;
        if (!(sel_o === 4'd5 && busy_o === 1'b0 && locked_o === 1'b0 && err_o === 1'b0)) begin
            n_err++;
            $display("FAIL manual_abort: sel=%0d busy=%b lock=%b err=%b, required sel=5 idle",
                     sel_o, busy_o, locked_o, err_o);
        end
        do_start();
        n_cmp++;
        if (!(sel_o === 4'd5 && busy_o === 1'b0)) begin
            n_err++;
            $display("FAIL manual_start_ignored: sel=%0d busy=%b, required sel=5 busy=0",
                     sel_o, busy_o);
        end
        manual_sel_i = 4'd9;
        @(negedge clk);
        n_cmp++;
        if (sel_o !== 4'd9) begin
            n_err++;
            $display("FAIL manual_follow: sel=%0d, required 9", sel_o);
        end
        manual_en_i = 0;
        snap = n_req;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (!(sel_o === 4'd9 && busy_o === 1'b0 && n_req == snap)) begin
            n_err++;
            $display("FAIL manual_release: sel=%0d busy=%b reqs=%0d, required sel=9 busy=0 reqs=0",
                     sel_o, busy_o, n_req - snap);
        end
    endtask

    task automatic test_reset_mid();
        int k = 0, snap;
        mode = 0;
        target_i = 16'd1000;
        do_start();
        while (sel_o !== 4'd12 && k < 300) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (sel_o !== 4'd12) begin
            n_err++;
            $display("FAIL reset_mid_reach: sel=%0d, required second trial sel=12", sel_o);
        end
        reset_i = 1;
        @(negedge clk);
        n_cmp++;
        if (!(sel_o === 4'd0 && busy_o === 1'b0 && locked_o === 1'b0 && meas_start_o === 1'b0)) begin
            n_err++;
            $display("FAIL reset_mid_state: sel=%0d busy=%b lock=%b, required sel=0 busy=0",
                     sel_o, busy_o, locked_o);
        end
        reset_i = 0;
        snap = n_req;
        repeat (60) @(negedge clk);
        n_cmp++;
        if (!(n_req == snap && busy_o === 1'b0)) begin
            n_err++;
            $display("FAIL reset_mid_quiet: reqs=%0d busy=%b, required reqs=0 busy=0",
                     n_req - snap, busy_o);
        end
    endtask

`ifdef CLK_GEN_TUNE_TRACK_EN
    task automatic test_track();
        int k = 0;
        test_search(0, 16'd1000, 1'b0, "track_lock");
        mode = 3;
        while (sel_o === 4'd10 && k < 400) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (!(sel_o === 4'd9 && locked_o === 1'b1 && busy_o === 1'b0)) begin
            n_err++;
            $display("FAIL track_step: sel=%0d lock=%b busy=%b, required sel=9 lock=1 busy=0",
                     sel_o, locked_o, busy_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_search(0, 16'd1000, 1'b0, "pattern");
        test_search(1, 16'd100, 1'b0, "all_pass");
        test_search(2, 16'd1000, 1'b0, "all_fail");
        test_random();
        test_timeout();
        test_manual();
        test_reset_mid();
        test_search(0, 16'd1000, 1'b1, "target_sampled");
`ifdef CLK_GEN_TUNE_TRACK_EN
        test_track();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
